// File: rtl/switch_allocator_if.sv
// Handshake bundle between the per-input VCs, the switch allocator
// and the crossbar.
interface switch_allocator_if #(
    parameter int IN_N      = 5,
    parameter int IN_N_W    = 3,
    parameter int OUT_N     = 5,
    parameter int OUT_N_W   = 3,
    parameter int FLIT_ID_W = 2
);
    logic [IN_N*OUT_N_W-1:0]   route_res_i;
    logic [IN_N-1:0]           route_res_vld_i;
    logic [IN_N-1:0]           data_vld_i;
    logic [IN_N*FLIT_ID_W-1:0] flit_id_i;
    logic [OUT_N-1:0]          out_rdy_i;
    logic [IN_N-1:0]           chan_alloc_o;
    logic [IN_N-1:0]           chan_rdy_o;
    logic [OUT_N*IN_N_W-1:0]   xbar_sel_o;
    logic [OUT_N-1:0]          xbar_vld_o;

    modport master (
        output route_res_i,
        output route_res_vld_i,
        output data_vld_i,
        output flit_id_i,
        output out_rdy_i,
        input  chan_alloc_o,
        input  chan_rdy_o,
        input  xbar_sel_o,
        input  xbar_vld_o
    );

    modport slave (
        input  route_res_i,
        input  route_res_vld_i,
        input  data_vld_i,
        input  flit_id_i,
        input  out_rdy_i,
        output chan_alloc_o,
        output chan_rdy_o,
        output xbar_sel_o,
        output xbar_vld_o
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator; each output stays locked
// to its winning input until that packet's tail flit has crossed.
module switch_allocator #(
    parameter int IN_N      = 5,
    parameter int IN_N_W    = 3,
    parameter int OUT_N     = 5,
    parameter int OUT_N_W   = 3,
    parameter int FLIT_ID_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    switch_allocator_if.slave   bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    localparam logic [FLIT_ID_W-1:0] FID_TAIL = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] FID_HT   = FLIT_ID_W'(3);

    logic [0:0]          r_state [OUT_N];
    logic [IN_N_W-1:0]   r_owner [OUT_N];
    logic [IN_N_W-1:0]   r_rr    [OUT_N];

    logic [IN_N-1:0]      w_req   [OUT_N];
    logic [IN_N_W-1:0]    w_win   [OUT_N];
    logic [FLIT_ID_W-1:0] w_fid   [IN_N];
    logic [OUT_N-1:0]     w_any;
    logic [OUT_N-1:0]     w_xfer;
    logic [OUT_N-1:0]     w_tail;
    logic [IN_N-1:0]      w_alloc;
    logic [IN_N-1:0]      w_rdy;
    logic [OUT_N*IN_N_W-1:0] w_sel;

    always_comb begin : fid_c
        for (int i = 0; i < IN_N; i++) begin
            w_fid[i] = bus.flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
        end
    end

    // Ownership is fully implied by the locked outputs.
    always_comb begin : lock_c
        w_alloc = '0;
        w_rdy   = '0;
        w_xfer  = '0;
        w_tail  = '0;
        w_sel   = '0;
        for (int o = 0; o < OUT_N; o++) begin
            w_sel[o*IN_N_W +: IN_N_W] = r_owner[o];
            if (r_state[o] == S_LOCKED) begin
                w_alloc[r_owner[o]] = 1'b1;
                if (bus.out_rdy_i[o] && rst_ni) begin
                    w_rdy[r_owner[o]] = 1'b1;
                end
                w_xfer[o] = rst_ni
                          & bus.data_vld_i[r_owner[o]]
                          & bus.out_rdy_i[o];
                w_tail[o] = (w_fid[r_owner[o]] == FID_TAIL)
                         || (w_fid[r_owner[o]] == FID_HT);
            end
        end
    end

    always_comb begin : req_c
        for (int o = 0; o < OUT_N; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < IN_N; i++) begin
                w_req[o][i] = bus.route_res_vld_i[i]
                            & ~w_alloc[i]
                            & (bus.route_res_i[i*OUT_N_W +: OUT_N_W]
                               == OUT_N_W'(o));
            end
        end
    end

    always_comb begin : arb_c
        logic [IN_N_W:0] idx;
        idx   = '0;
        w_any = '0;
        for (int o = 0; o < OUT_N; o++) begin
            w_win[o] = '0;
            for (int k = 0; k < IN_N; k++) begin
                idx = {1'b0, r_rr[o]} + (IN_N_W+1)'(k);
                if (idx >= (IN_N_W+1)'(IN_N)) begin
                    idx = idx - (IN_N_W+1)'(IN_N);
                end
                if (!w_any[o] && w_req[o][idx[IN_N_W-1:0]]) begin
                    w_any[o] = 1'b1;
                    w_win[o] = idx[IN_N_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int o = 0; o < OUT_N; o++) begin
                r_state[o] <= S_IDLE;
                r_owner[o] <= '0;
                r_rr[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < OUT_N; o++) begin
                case (r_state[o])
                    S_IDLE: begin
                        if (w_any[o]) begin
                            r_state[o] <= S_LOCKED;
                            r_owner[o] <= w_win[o];
                            r_rr[o]    <= (w_win[o] == IN_N_W'(IN_N-1))
                                        ? '0 : w_win[o] + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (w_xfer[o] && w_tail[o]) begin
                            r_state[o] <= S_IDLE;
                        end
                    end
                    default: r_state[o] <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.chan_alloc_o = w_alloc;
    assign bus.chan_rdy_o   = w_rdy;
    assign bus.xbar_vld_o   = w_xfer;
    assign bus.xbar_sel_o   = w_sel;
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Router stage directly downstream of the per-input virtual_channel instances.
- Consumes each VC's route result (route_res_o/route_res_vld_o) and flit-valid/flit-ID, and arbitrates every router output port among the requesting inputs with round-robin fairness.
- Returns chan_alloc_i and chan_rdy_i to the winning VC.
- Locks the output to that input for the whole packet, until the tail flit is transferred, and drives crossbar select/valid.

Parameters:
- IN_N, 5, number of router inputs (one VC each).
- IN_N_W, 3, width of an input index; 2**IN_N_W >= IN_N.
- OUT_N, 5, number of router outputs.
- OUT_N_W, 3, width of a route result (binary output index).
- FLIT_ID_W, 2, flit type field width.
- FLIT_ID encoding (fixed): 2'b10 HEADER, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEADER_TAIL (single-flit packet).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- route_res_i  input  IN_N*OUT_N_W  per-input requested output index; input i occupies slice [i*OUT_N_W +: OUT_N_W].
- route_res_vld_i  input  IN_N  per-input header present and route valid.
- data_vld_i  input  IN_N  per-input flit valid at VC head.
- flit_id_i  input  IN_N*FLIT_ID_W  per-input flit type of the head flit.
- out_rdy_i  input  OUT_N  downstream buffer at output o not full.
- chan_alloc_o  output  IN_N  input i currently owns an output; maps to the VC's chan_alloc_i.
- chan_rdy_o  output  IN_N  owned output can accept a flit this cycle; maps to the VC's chan_rdy_i.
- xbar_sel_o  output  OUT_N*IN_N_W  per-output selected input index.
- xbar_vld_o  output  OUT_N  flit transferred through output o this cycle.

Behaviour:
- Per output o: 2-state FSM, IDLE / LOCKED.
- Per output o registers: owner[o] (IN_N_W bits) and rr_ptr[o] (IN_N_W bits).
- Reset (rst_ni=0 at posedge):
  - All FSMs go to IDLE; owner and rr_ptr go to 0.
  - chan_alloc_o=0 and xbar_sel_o=0.
  - chan_rdy_o and xbar_vld_o are 0 as a consequence.
  - Reset mid-packet drops all locks; no flit counts as transferred in that cycle.
- Request: req[o][i] = route_res_vld_i[i] & (route_res_i slice == o) & ~chan_alloc_o[i].
  - Inputs already holding a lock never request.
  - route_res values >= OUT_N match no output and are never granted.
- IDLE -> LOCKED:
  - Taken in any cycle with at least one req[o][i].
  - Winner is the first requesting index scanning rr_ptr[o], rr_ptr[o]+1, ... modulo IN_N.
  - At the clock edge: owner[o] = winner, rr_ptr[o] = (winner+1) mod IN_N (wraps IN_N-1 -> 0), chan_alloc_o[winner] = 1.
  - Latency: request in cycle t -> chan_alloc_o high in cycle t+1.
- Two outputs granting the same input in the same cycle is impossible, since an input requests exactly one output.
- Transfer at output o (combinational): xfer[o] = LOCKED & data_vld_i[owner] & out_rdy_i[o].
  - xbar_vld_o[o] = xfer[o].
  - chan_rdy_o[owner] = LOCKED & out_rdy_i[o].
  - chan_rdy_o of unlocked inputs is 0.
- LOCKED -> IDLE:
  - Taken at the edge ending a cycle with xfer[o] and flit_id_i[owner] equal to TAIL or HEADER_TAIL.
  - chan_alloc_o[owner] clears at the same edge.
  - The output re-arbitrates in the next cycle, so a new grant is visible 2 cycles after the tail transfer.
  - out_rdy_i low during the tail cycle: no transfer and no release.
- xbar_sel_o[o] = owner[o] while LOCKED. It holds its last value while IDLE.

Test Plan:
- Reset then idle: all outputs 0; route_res_vld_i=0 for 10 cycles -> chan_alloc_o stays 5'b00000.
- Single input: input 2 requests out 3, HEADER-BODY-TAIL with out_rdy_i all 1.
  - chan_alloc_o=5'b00100 one cycle after the request.
  - xbar_sel_o slice 3 = 2, with xbar_vld_o[3] high for 3 cycles.
  - chan_alloc_o clears the cycle after the TAIL.
- Round-robin: inputs 0, 1 and 4 all request out 1 continuously with single-flit (HEADER_TAIL) packets.
  - Grant order is 0, 1, 4, 0, ...
  - rr_ptr wraps after 4.
- Backpressure: out_rdy_i[3]=0 while locked mid-packet.
  - chan_rdy_o and xbar_vld_o[3] stay 0.
  - Lock is held; release occurs only after the TAIL transfers once out_rdy_i[3]=1.
- Parallel outputs: input 0 -> out 2 and input 1 -> out 4 in the same cycle.
  - Both granted next cycle; chan_alloc_o=5'b00011.
- Boundary and reset:
  - route_res=7 with valid -> never granted.
  - Reset asserted mid-packet -> next cycle all locks are cleared and the FSMs are IDLE.
